conware_frame: RTL and testbench
================================

# conware_frame

Full-frame Game-of-Life engine: accepts one WIDTH×HEIGHT frame of colour pixels on an AXI4-Stream slave and stores it as a cell grid. It computes one generation, one row per cycle, and streams the next-generation frame out on an AXI4-Stream master. It replaces the single-row pass-through top by absorbing the input-buffer, cell-update and output-buffer roles. It sits between the video DMA read and write channels.

## Interface
- DWIDTH, 32, pixel/data width in bits; must be 32 (TKEEP/TSTRB are 4 bits)
- WIDTH, 32, cells per row (≥3)
- HEIGHT, 32, rows per frame (≥3)
- ALIVE_COLOR, 32'hFFFFFFFF, output pixel value for a live cell
- DEAD_COLOR, 32'h00000000, output pixel value for a dead cell
- ACLK  input  1  sole clock; all logic on rising edge
- ARESETN  input  1  asynchronous, active-low reset
- S_AXIS_TVALID  input  1  input pixel valid
- S_AXIS_TREADY  output  1  input pixel accepted
- S_AXIS_TDATA  input  DWIDTH  input pixel, raster order
- S_AXIS_TLAST  input  1  last pixel of frame
- M_AXIS_TVALID  output  1  output pixel valid
- M_AXIS_TREADY  input  1  downstream ready
- M_AXIS_TDATA  output  DWIDTH  output pixel
- M_AXIS_TLAST  output  1  last pixel of frame
- M_AXIS_TKEEP  output  4  constant 4'hF
- M_AXIS_TSTRB  output  4  constant 4'hF
- frame_err  output  1  sticky; input TLAST position mismatch
- gen_count  output  16  frames emitted, wraps at 65535→0

## Operation
- FSM states: LOAD, COMPUTE, EMIT; reset state LOAD.
- LOAD behaviour:
  - S_AXIS_TREADY=1. Each accepted beat writes cell[idx] = (TDATA != DEAD_COLOR), then idx++.
  - Pixel order: idx = row*WIDTH + col.
- LOAD exits to COMPUTE on whichever comes first:
  - a beat accepted with TLAST=1;
  - acceptance of beat idx = WIDTH*HEIGHT-1.
- LOAD boundary cases:
  - Early TLAST (idx < last): the remaining cells are cleared to dead and frame_err is set.
  - Final beat without TLAST: frame_err is set and the FSM proceeds normally. The next beat is treated as the start of a new frame.
- COMPUTE: row counter r runs 0..HEIGHT-1, one row per cycle.
  - next[r][c] = (n==3) | (cell[r][c] & n==2), where n is the 4-bit sum of the 8 neighbours from rows r-1, r, r+1.
  - Results are written into a separate next-grid, so the current grid is unchanged during COMPUTE.
  - After r=HEIGHT-1, go to EMIT.
- EMIT:
  - M_AXIS_TVALID=1 and M_AXIS_TDATA = next[idx] ? ALIVE_COLOR : DEAD_COLOR.
  - idx advances only on TVALID&TREADY.
  - M_AXIS_TLAST=1 exactly at idx=WIDTH*HEIGHT-1.
  - On the final handshake: gen_count++, then go to LOAD.
- TDATA, TLAST and idx are held stable while TREADY=0.
- frame_err clears only on reset.

## Timing
- While ARESETN=0, the following outputs are 0: S_AXIS_TREADY, M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TLAST, frame_err, gen_count. The grid and counters are cleared.
- S_AXIS_TREADY first rises on the first ACLK edge after ARESETN release, via a run flag reset to 0.
- Latency: if the final input beat is accepted at edge t, then:
  - COMPUTE occupies cycles t+1..t+HEIGHT;
  - M_AXIS_TVALID is first high in cycle t+HEIGHT+1.
- Throughput: one beat per cycle in both LOAD and EMIT; no input is accepted during COMPUTE or EMIT.
- Reset mid-operation (any state): abort immediately. The partial frame is discarded; M_AXIS_TVALID drops asynchronously.

## Configuration
- CONWARE_WRAP_EN defined: toroidal edges. Row -1 aliases row HEIGHT-1, column -1 aliases column WIDTH-1, and symmetrically at the far edges.
- CONWARE_WRAP_EN undefined: cells outside the grid count as dead.

## Structure
- Package conware_pkg holds:
  - the state enum (LOAD/COMPUTE/EMIT);
  - the neighbour-count width constant (4);
  - default colour constants.
- Sub-module conware_row_step: combinational. Inputs are above/cur/below rows (WIDTH bits each); output is the next row (WIDTH bits). Edge handling follows CONWARE_WRAP_EN. The top instantiates it once and muxes rows by r.

## Test plan
All scenarios use WIDTH=8, HEIGHT=8.
- Blinker, no wrap: live (3,2),(3,3),(3,4) → output live exactly (2,3),(3,3),(4,3). A second frame of that output returns the original. TLAST is only on beat 63; gen_count=2.
- Block still life: 2×2 live at (0,0) → identical output without wrap. With CONWARE_WRAP_EN, a 2×2 live at (7,7),(7,0),(0,7),(0,0) is also still.
- Backpressure: M_AXIS_TREADY toggles 1-0-0-1 throughout EMIT → 64 handshakes, no beat lost or duplicated, TDATA stable during stalls. First TVALID occurs exactly 9 cycles after the last input edge.
- Early TLAST at beat 20 → frame_err=1; cells 21..63 dead; output is a 64-beat frame.
- Missing TLAST: 64 beats with no TLAST → frame_err=1 and a normal 64-beat output frame.
- Reset mid-EMIT after 10 beats → TVALID=0 immediately. After release, TREADY=1 on the first edge, gen_count=0, and a fresh blinker frame is processed correctly.

Source files
------------

// File: rtl/conware_pkg.sv
// conware_frame shared types and constants.
// CONWARE_WRAP_EN selects toroidal edges in the engine.
package conware_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    EMIT    = 2'd2
  } state_t;

  localparam int NBR_W = 4;

  localparam logic [31:0] ALIVE_DEF = 32'hFFFF_FFFF;
  localparam logic [31:0] DEAD_DEF  = 32'h0000_0000;

endpackage

// File: rtl/conware_row_step.sv
// One-row Game-of-Life update, purely combinational.
// CONWARE_WRAP_EN wraps columns; otherwise off-grid cells are dead.
module conware_row_step
  import conware_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] above,
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] below,
  output logic [WIDTH-1:0] nxt
);

  // Halo-extended rows: bit c+1 holds column c.
  logic [WIDTH+1:0] a_x;
  logic [WIDTH+1:0] c_x;
  logic [WIDTH+1:0] b_x;

`ifdef CONWARE_WRAP_EN
  assign a_x = {above[0], above, above[WIDTH-1]};
  assign c_x = {cur[0], cur, cur[WIDTH-1]};
  assign b_x = {below[0], below, below[WIDTH-1]};
`else
  assign a_x = {1'b0, above, 1'b0};
  assign c_x = {1'b0, cur, 1'b0};
  assign b_x = {1'b0, below, 1'b0};
`endif

  for (genvar c = 0; c < WIDTH; c++) begin : g_col
    logic [NBR_W-1:0] n;
    assign n = NBR_W'(a_x[c]) + NBR_W'(a_x[c+1])
             + NBR_W'(a_x[c+2]) + NBR_W'(c_x[c])
             + NBR_W'(c_x[c+2]) + NBR_W'(b_x[c])
             + NBR_W'(b_x[c+1]) + NBR_W'(b_x[c+2]);
    assign nxt[c] = (n == NBR_W'(3))
                  | (cur[c] & (n == NBR_W'(2)));
  end

endmodule

// File: rtl/conware_frame.sv
// Full-frame Game-of-Life engine between AXI4-Stream ports.
// CONWARE_WRAP_EN selects toroidal edges.
module conware_frame
  import conware_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int WIDTH  = 32,
  parameter int HEIGHT = 32,
  parameter logic [DWIDTH-1:0] ALIVE_COLOR = ALIVE_DEF,
  parameter logic [DWIDTH-1:0] DEAD_COLOR  = DEAD_DEF
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              S_AXIS_TVALID,
  output logic              S_AXIS_TREADY,
  input  logic [DWIDTH-1:0] S_AXIS_TDATA,
  input  logic              S_AXIS_TLAST,
  output logic              M_AXIS_TVALID,
  input  logic              M_AXIS_TREADY,
  output logic [DWIDTH-1:0] M_AXIS_TDATA,
  output logic              M_AXIS_TLAST,
  output logic [3:0]        M_AXIS_TKEEP,
  output logic [3:0]        M_AXIS_TSTRB,
  output logic              frame_err,
  output logic [15:0]       gen_count
);

  localparam int N  = WIDTH * HEIGHT;
  localparam int IW = $clog2(N);
  localparam int RW = $clog2(HEIGHT);
  localparam logic [IW-1:0] LAST  = IW'(N - 1);
  localparam logic [RW-1:0] RLAST = RW'(HEIGHT - 1);

  state_t state;
  state_t state_n;

  logic          run;
  logic [IW-1:0] idx;
  logic [RW-1:0] r;
  logic [N-1:0]  cells;
  logic [N-1:0]  nxt;

  logic [WIDTH-1:0] above;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] below;
  logic [WIDTH-1:0] step;

  int ra;
  int rb;

  logic in_fire;
  logic out_fire;
  logic at_last;
  logic in_end;

  assign S_AXIS_TREADY = run & (state == LOAD);
  assign M_AXIS_TVALID = (state == EMIT);
  assign M_AXIS_TDATA  = !M_AXIS_TVALID ? '0
                       : nxt[idx] ? ALIVE_COLOR
                       : DEAD_COLOR;
  assign M_AXIS_TLAST  = M_AXIS_TVALID & at_last;
  assign M_AXIS_TKEEP  = 4'hF;
  assign M_AXIS_TSTRB  = 4'hF;

  assign in_fire  = S_AXIS_TVALID & S_AXIS_TREADY;
  assign out_fire = M_AXIS_TVALID & M_AXIS_TREADY;
  assign at_last  = (idx == LAST);
  assign in_end   = S_AXIS_TLAST | at_last;

  always_comb begin
    ra = (r == '0) ? HEIGHT - 1 : int'(r) - 1;
    rb = (r == RLAST) ? 0 : int'(r) + 1;
    cur   = cells[int'(r)*WIDTH +: WIDTH];
    above = cells[ra*WIDTH +: WIDTH];
    below = cells[rb*WIDTH +: WIDTH];
`ifdef CONWARE_WRAP_EN
`else
    if (r == '0)   above = '0;
    if (r == RLAST) below = '0;
`endif
  end

  conware_row_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .above (above),
    .cur   (cur),
    .below (below),
    .nxt   (step)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      LOAD:    if (in_fire && in_end) state_n = COMPUTE;
      COMPUTE: if (r == RLAST) state_n = EMIT;
      EMIT:    if (out_fire && at_last) state_n = LOAD;
      default: state_n = LOAD;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state     <= LOAD;
      run       <= 1'b0;
      idx       <= '0;
      r         <= '0;
      cells     <= '0;
      nxt       <= '0;
      frame_err <= 1'b0;
      gen_count <= '0;
    end else begin
      state <= state_n;
      run   <= 1'b1;
      unique case (state)
        LOAD: begin
          if (in_fire) begin
            cells[idx] <= (S_AXIS_TDATA != DEAD_COLOR);
            // TLAST must coincide with the final cell.
            if (S_AXIS_TLAST != at_last) frame_err <= 1'b1;
            idx <= in_end ? '0 : idx + IW'(1);
            r   <= '0;
          end
        end
        COMPUTE: begin
          nxt[int'(r)*WIDTH +: WIDTH] <= step;
          r <= (r == RLAST) ? '0 : r + RW'(1);
        end
        EMIT: begin
          if (out_fire) begin
            if (at_last) begin
              idx       <= '0;
              gen_count <= gen_count + 16'd1;
              // Short frames leave the tail dead.
              cells     <= '0;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conware_frame.sv
// Self-checking bench for conware_frame (8x8 grid).
// Reference model counts neighbours directly from the Life rules.
module tb_conware_frame;

  localparam int W = 8;
  localparam int H = 8;
  localparam int N = W * H;
  localparam logic [31:0] ALIVE = 32'hFFFF_FFFF;
  localparam logic [31:0] DEAD  = 32'h0000_0000;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        S_AXIS_TVALID = 1'b0;
  logic        S_AXIS_TREADY;
  logic [31:0] S_AXIS_TDATA = '0;
  logic        S_AXIS_TLAST = 1'b0;
  logic        M_AXIS_TVALID;
  logic        M_AXIS_TREADY = 1'b0;
  logic [31:0] M_AXIS_TDATA;
  logic        M_AXIS_TLAST;
  logic [3:0]  M_AXIS_TKEEP;
  logic [3:0]  M_AXIS_TSTRB;
  logic        frame_err;
  logic [15:0] gen_count;

  int checks = 0;
  int errors = 0;
  int gens = 0;

  always #5 ACLK = ~ACLK;

  conware_frame #(
    .DWIDTH      (32),
    .WIDTH       (W),
    .HEIGHT      (H),
    .ALIVE_COLOR (ALIVE),
    .DEAD_COLOR  (DEAD)
  ) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .S_AXIS_TVALID (S_AXIS_TVALID),
    .S_AXIS_TREADY (S_AXIS_TREADY),
    .S_AXIS_TDATA  (S_AXIS_TDATA),
    .S_AXIS_TLAST  (S_AXIS_TLAST),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TREADY (M_AXIS_TREADY),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .M_AXIS_TKEEP  (M_AXIS_TKEEP),
    .M_AXIS_TSTRB  (M_AXIS_TSTRB),
    .frame_err     (frame_err),
    .gen_count     (gen_count)
  );

  function automatic void life(input bit g[N], output bit o[N]);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        int n;
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            int rr;
            int cc;
            rr = r + dr;
            cc = c + dc;
`ifdef CONWARE_WRAP_EN
            rr = (rr + H) % H;
            cc = (cc + W) % W;
`endif
            if ((dr != 0 || dc != 0) && rr >= 0 && rr < H
                && cc >= 0 && cc < W)
              n += int'(g[rr*W+cc]);
          end
        end
        o[r*W+c] = (n == 3) || (g[r*W+c] && n == 2);
      end
    end
  endfunction

  function automatic void rand_grid(input int pct, output bit g[N]);
    for (int i = 0; i < N; i++)
      g[i] = ($urandom_range(0, 99) < pct);
  endfunction

  function automatic int first_diff(input bit a[N], input bit b[N]);
    for (int i = 0; i < N; i++)
      if (a[i] != b[i]) return i;
    return -1;
  endfunction

  task automatic do_reset();
    #3 ARESETN = 1'b0;
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST  = 1'b0;
    M_AXIS_TREADY = 1'b0;
    gens = 0;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    ARESETN = 1'b1;
  endtask

  // tl_at: beat carrying TLAST, or -1 for a full frame without it.
  task automatic send_frame(input bit g[N], input int tl_at);
    int nb;
    int w;
    nb = (tl_at >= 0) ? tl_at + 1 : N;
    for (int b = 0; b < nb; b++) begin
      @(negedge ACLK);
      S_AXIS_TVALID = 1'b1;
      S_AXIS_TDATA  = g[b] ? ($urandom | 32'h1) : DEAD;
      S_AXIS_TLAST  = (b == tl_at);
      w = 0;
      while (!S_AXIS_TREADY && w < 100) begin
        @(negedge ACLK);
        w++;
      end
      if (w >= 100) begin
        checks++;
        errors++;
        $display("FAIL send_timeout beat %0d ready %b want 1",
                 b, S_AXIS_TREADY);
        S_AXIS_TVALID = 1'b0;
        return;
      end
      @(posedge ACLK);
      #1;
    end
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST  = 1'b0;
  endtask

  // pat 0: always ready, 1: 1-0-0-1, 2: random.
  task automatic recv_frame(input int pat, input int max_beats,
                            output bit got[N], output int first_j);
    int beats;
    int j;
    bit stalled;
    logic [31:0] pd;
    logic pl;
    bit pat4[4];
    pat4[0] = 1'b1; pat4[1] = 1'b0; pat4[2] = 1'b0; pat4[3] = 1'b1;
    beats = 0;
    j = 0;
    first_j = -1;
    stalled = 1'b0;
    pd = '0;
    pl = 1'b0;
    for (int i = 0; i < N; i++) got[i] = 1'b0;
    while (beats < max_beats && j < 3000) begin
      @(negedge ACLK);
      j++;
      if (pat == 0)      M_AXIS_TREADY = 1'b1;
      else if (pat == 1) M_AXIS_TREADY = pat4[(beats + (stalled ? 1 : 0) + j) % 4];
      else               M_AXIS_TREADY = $urandom_range(0, 1) != 0;
      if (M_AXIS_TVALID) begin
        if (first_j < 0) first_j = j;
        if (stalled) begin
          checks++;
          if (M_AXIS_TDATA !== pd || M_AXIS_TLAST !== pl) begin
            errors++;
            $display("FAIL stall_hold beat %0d data %h last %b want %h %b",
                     beats, M_AXIS_TDATA, M_AXIS_TLAST, pd, pl);
          end
        end
        if (M_AXIS_TREADY) begin
          checks++;
          if (M_AXIS_TLAST !== (beats == N - 1)
              || (M_AXIS_TDATA !== ALIVE && M_AXIS_TDATA !== DEAD)) begin
            errors++;
            $display("FAIL beat_fmt beat %0d last %b data %h want last %b",
                     beats, M_AXIS_TLAST, M_AXIS_TDATA, beats == N - 1);
          end
          got[beats] = (M_AXIS_TDATA === ALIVE);
          beats++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          pd = M_AXIS_TDATA;
          pl = M_AXIS_TLAST;
        end
      end
    end
    if (beats < max_beats) begin
      checks++;
      errors++;
      $display("FAIL recv_timeout beats %0d want %0d", beats, max_beats);
    end
    @(posedge ACLK);
    #1;
    M_AXIS_TREADY = 1'b0;
    if (beats == N) gens++;
  endtask

  task automatic run_frame(input string name, input bit g[N],
                           input int tl_at, input int pat,
                           output bit got[N]);
    bit exp_g[N];
    int fj;
    int d;
    send_frame(g, tl_at);
    recv_frame(pat, N, got, fj);
    life(g, exp_g);
    d = first_diff(got, exp_g);
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL %s cell %0d got %b want %b",
               name, d, got[d], exp_g[d]);
    end
    checks++;
    if (M_AXIS_TVALID !== 1'b0 || S_AXIS_TREADY !== 1'b1) begin
      errors++;
      $display("FAIL %s_return valid %b ready %b want 0 1",
               name, M_AXIS_TVALID, S_AXIS_TREADY);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (S_AXIS_TREADY !== 1'b0 || M_AXIS_TVALID !== 1'b0
        || M_AXIS_TDATA !== '0 || M_AXIS_TLAST !== 1'b0
        || frame_err !== 1'b0 || gen_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_out rdy %b vld %b data %h last %b err %b gen %0d want zeros",
               S_AXIS_TREADY, M_AXIS_TVALID, M_AXIS_TDATA,
               M_AXIS_TLAST, frame_err, gen_count);
    end
    checks++;
    if (M_AXIS_TKEEP !== 4'hF || M_AXIS_TSTRB !== 4'hF) begin
      errors++;
      $display("FAIL keep_strb %h %h want f f", M_AXIS_TKEEP, M_AXIS_TSTRB);
    end
    @(negedge ACLK);
    ARESETN = 1'b1;
    #1;
    checks++;
    if (S_AXIS_TREADY !== 1'b0) begin
      errors++;
      $display("FAIL ready_pre_edge %b want 0", S_AXIS_TREADY);
    end
    @(posedge ACLK);
    #1;
    checks++;
    if (S_AXIS_TREADY !== 1'b1) begin
      errors++;
      $display("FAIL ready_first_edge %b want 1", S_AXIS_TREADY);
    end
  endtask

  task automatic blinker_check(input string name);
    bit g[N];
    bit o1[N];
    bit o2[N];
    bit want[N];
    int d;
    for (int i = 0; i < N; i++) begin
      g[i] = 1'b0;
      want[i] = 1'b0;
    end
    g[3*W+2] = 1'b1; g[3*W+3] = 1'b1; g[3*W+4] = 1'b1;
    want[2*W+3] = 1'b1; want[3*W+3] = 1'b1; want[4*W+3] = 1'b1;
    run_frame(name, g, N - 1, 0, o1);
    d = first_diff(o1, want);
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL %s_vertical cell %0d got %b want %b",
               name, d, o1[d], want[d]);
    end
    run_frame(name, o1, N - 1, 0, o2);
    d = first_diff(o2, g);
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL %s_period2 cell %0d got %b want %b",
               name, d, o2[d], g[d]);
    end
    checks++;
    if (gen_count !== 16'(gens)) begin
      errors++;
      $display("FAIL %s_gen got %0d want %0d", name, gen_count, gens);
    end
  endtask

  task automatic test_blinker();
    blinker_check("blinker");
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL blinker_err got %b want 0", frame_err);
    end
  endtask

  task automatic test_block();
    bit g[N];
    bit o[N];
    int d;
    for (int i = 0; i < N; i++) g[i] = 1'b0;
    g[0] = 1'b1; g[1] = 1'b1; g[W] = 1'b1; g[W+1] = 1'b1;
    run_frame("block", g, N - 1, 0, o);
    d = first_diff(o, g);
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL block_still cell %0d got %b want %b", d, o[d], g[d]);
    end
`ifdef CONWARE_WRAP_EN
    for (int i = 0; i < N; i++) g[i] = 1'b0;
    g[7*W+7] = 1'b1; g[7*W] = 1'b1; g[7] = 1'b1; g[0] = 1'b1;
    run_frame("block_wrap", g, N - 1, 0, o);
    d = first_diff(o, g);
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL block_wrap_still cell %0d got %b want %b",
               d, o[d], g[d]);
    end
`endif
  endtask

  task automatic test_backpressure();
    bit g[N];
    bit o[N];
    bit e[N];
    int fj;
    int d;
    rand_grid(40, g);
    send_frame(g, N - 1);
    recv_frame(1, N, o, fj);
    checks++;
    if (fj != H + 1) begin
      errors++;
      $display("FAIL first_valid_lat got %0d want %0d", fj, H + 1);
    end
    life(g, e);
    d = first_diff(o, e);
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL backpressure cell %0d got %b want %b", d, o[d], e[d]);
    end
  endtask

  task automatic test_random();
    bit g[N];
    bit o[N];
    for (int k = 0; k < 4; k++) begin
      rand_grid($urandom_range(15, 60), g);
      run_frame("random", g, N - 1, 2, o);
    end
    checks++;
    if (gen_count !== 16'(gens)) begin
      errors++;
      $display("FAIL random_gen got %0d want %0d", gen_count, gens);
    end
  endtask

  task automatic test_early_tlast();
    bit g[N];
    bit o[N];
    rand_grid(50, g);
    send_frame(g, 20);
    for (int i = 21; i < N; i++) g[i] = 1'b0;
    begin
      bit e[N];
      int fj;
      int d;
      recv_frame(0, N, o, fj);
      life(g, e);
      d = first_diff(o, e);
      checks++;
      if (d >= 0) begin
        errors++;
        $display("FAIL early_tlast cell %0d got %b want %b", d, o[d], e[d]);
      end
    end
    checks++;
    if (frame_err !== 1'b1) begin
      errors++;
      $display("FAIL early_tlast_err got %b want 1", frame_err);
    end
  endtask

  task automatic test_missing_tlast();
    bit g[N];
    bit o[N];
    do_reset();
    @(posedge ACLK);
    rand_grid(45, g);
    run_frame("missing_tlast", g, -1, 0, o);
    checks++;
    if (frame_err !== 1'b1) begin
      errors++;
      $display("FAIL missing_tlast_err got %b want 1", frame_err);
    end
  endtask

  task automatic test_reset_mid_emit();
    bit g[N];
    bit o[N];
    int fj;
    do_reset();
    @(posedge ACLK);
    rand_grid(50, g);
    send_frame(g, N - 1);
    recv_frame(0, 10, o, fj);
    #2 ARESETN = 1'b0;
    #1;
    checks++;
    if (M_AXIS_TVALID !== 1'b0 || gen_count !== 16'd0
        || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset valid %b gen %0d err %b want 0 0 0",
               M_AXIS_TVALID, gen_count, frame_err);
    end
    gens = 0;
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(posedge ACLK);
    #1;
    checks++;
    if (S_AXIS_TREADY !== 1'b1 || gen_count !== 16'd0) begin
      errors++;
      $display("FAIL after_reset ready %b gen %0d want 1 0",
               S_AXIS_TREADY, gen_count);
    end
    blinker_check("blinker_after_reset");
  endtask

  initial begin
    test_reset();
    test_blinker();
    test_block();
    test_backpressure();
    test_random();
    test_early_tlast();
    test_missing_tlast();
    test_reset_mid_emit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
